// File: rtl/cpu_fetch.sv
// Instruction fetch: byte-serial reads from program memory, assembles
// 1-3 byte instructions and hands them to the decoder via valid/ready.
module cpu_fetch #(
  parameter int unsigned          ADDR_W   = 11,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              mem_readwrite,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [15:0]       instr_operand,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CAP,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        len_q, len_d;
  logic [7:0]        op_q, op_d;
  logic [15:0]       opnd_q, opnd_d;
  logic              valid_q, valid_d;

  logic              fire;
  logic [1:0]        dec_len;
  logic [1:0]        cur_len;
  logic [1:0]        idx_inc;

  assign fire    = valid_q & instr_ready;
  assign idx_inc = idx_q + 2'd1;

  always_comb begin
    dec_len = 2'd3;
    unique case (1'b1)
      mem_rdata[7:6] == 2'b00: dec_len = 2'd1;
      mem_rdata[7:6] == 2'b01: dec_len = 2'd2;
      mem_rdata[7]:            dec_len = 2'd3;
      default:                 dec_len = 2'd3;
    endcase
  end

  // byte 0 determines the length of the instruction being assembled
  assign cur_len = (idx_q == 2'd0) ? dec_len : len_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    idx_d   = idx_q;
    len_d   = len_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = REQ;
      end
      REQ: begin
        state_d = CAP;
      end
      CAP: begin
        pc_d  = pc_q + ADDR_W'(1);
        idx_d = idx_inc;
        unique case (idx_q)
          2'd0: begin
            op_d  = mem_rdata;
            len_d = dec_len;
            ipc_d = pc_q;
          end
          2'd1:    opnd_d[7:0]  = mem_rdata;
          default: opnd_d[15:8] = mem_rdata;
        endcase
        if (idx_inc == cur_len) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end else begin
          state_d = REQ;
        end
      end
      HOLD: begin
        if (fire) begin
          valid_d = 1'b0;
          idx_d   = 2'd0;
          opnd_d  = '0;
          state_d = enable ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // redirect wins over everything, including a coincident fire
    if (redirect_valid) begin
      pc_d    = redirect_addr;
      idx_d   = 2'd0;
      valid_d = 1'b0;
      opnd_d  = '0;
      state_d = enable ? REQ : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ipc_q   <= '0;
      idx_q   <= 2'd0;
      len_q   <= 2'd0;
      op_q    <= 8'd0;
      opnd_q  <= 16'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      valid_q <= valid_d;
    end
  end

  assign mem_readwrite = 1'b1;
  assign mem_addr      = pc_q;
  assign instr_valid   = valid_q;
  assign instr_opcode  = op_q;
  assign instr_operand = opnd_q;
  assign instr_len     = len_q;
  assign instr_pc      = ipc_q;

endmodule
